dma_copy_master: RTL

- Bus initiator (master) for the byte-wide memory bus used by the program ROM and the 32KB RAM.
- Copies LENGTH bytes from a source address to a destination address: one read cycle, then one write cycle, per byte.
- Arbitrates with the CPU through bus_req/bus_grant.
- Used for boot-time ROM→RAM program loading and for block moves.

---
 rtl/bus_pkg.sv | 22 ++
 rtl/dma_copy_master.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the byte-wide program-ROM / RAM bus and the DMA copy master.
package bus_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;

  localparam logic [15:0] RAM_BASE      = 16'h0000;
  localparam int          RAM_SIZE      = 32768;
  localparam logic [15:0] PIO_DDR_ADDR  = 16'hFE00;
  localparam logic [15:0] PIO_PORT_ADDR = 16'hFE01;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    VFY,
    REL,
    DONE
  } dma_state_t;

endpackage

// File: rtl/dma_copy_master.sv
// Byte-at-a-time bus copy engine (read src, write dst) that arbitrates with the CPU.
// Define DMA_COPY_VERIFY_EN to read back every written byte and flag mismatches on err.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | bus_req raised, waiting for bus_grant
// RD    | read strobe at src, byte captured
// WR    | write strobe at dst
// VFY   | read-back of dst compared to the copied byte (verify builds only)
// REL   | bus released for one cycle at a burst boundary
// DONE  | one-cycle completion pulse
module dma_copy_master
  import bus_pkg::*;
#(
  parameter int ADDR_W = BUS_ADDR_W,
  parameter int DATA_W = BUS_DATA_W,
  parameter int BURST  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              bus_req,
  input  logic              bus_grant,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_cs,
  output logic              bus_we,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] BURST_N = (ADDR_W+1)'(BURST);

  dma_state_t        state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] rem_q;
  logic [ADDR_W:0]   burst_q;
  logic [DATA_W-1:0] byte_q;

  logic [ADDR_W:0]   burst_nxt;
  dma_state_t        adv_state;
  logic              adv_en;
  logic              vfy_fail;

  assign burst_nxt = burst_q + 1'b1;

  always_comb begin
    if (rem_q == ADDR_W'(1))
      adv_state = DONE;
    else if ((BURST != 0) && (burst_nxt == BURST_N))
      adv_state = REL;
    else
      adv_state = RD;
  end

`ifdef DMA_COPY_VERIFY_EN
  assign adv_en   = bus_grant && (state == VFY) && (bus_rdata == byte_q);
  assign vfy_fail = bus_grant && (state == VFY) && (bus_rdata != byte_q);
`else
  assign adv_en   = bus_grant && (state == WR);
  assign vfy_fail = 1'b0;
`endif

  // Strobes are gated by grant so a lost grant stalls the cycle without a bus access.
  always_comb begin
    bus_cs    = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (bus_grant) begin
      case (state)
        RD: begin
          bus_cs   = 1'b1;
          bus_addr = src_q;
        end
        WR: begin
          bus_cs    = 1'b1;
          bus_we    = 1'b1;
          bus_addr  = dst_q;
          bus_wdata = byte_q;
        end
`ifdef DMA_COPY_VERIFY_EN
        VFY: begin
          bus_cs   = 1'b1;
          bus_addr = dst_q;
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      burst_q <= '0;
      byte_q  <= '0;
      bus_req <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          if (length != '0) begin
            src_q   <= src_addr;
            dst_q   <= dst_addr;
            rem_q   <= length;
            burst_q <= '0;
            err     <= 1'b0;
            busy    <= 1'b1;
            bus_req <= 1'b1;
            state   <= REQ;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        REQ: if (bus_grant) state <= RD;
        RD: if (bus_grant) begin
          byte_q <= bus_rdata;
          state  <= WR;
        end
`ifdef DMA_COPY_VERIFY_EN
        WR: if (bus_grant) state <= VFY;
`endif
        REL: begin
          burst_q <= '0;
          bus_req <= 1'b1;
          state   <= REQ;
        end
        DONE: state <= IDLE;
        default: ;
      endcase

      if (adv_en) begin
        src_q   <= src_q + 1'b1;
        dst_q   <= dst_q + 1'b1;
        rem_q   <= rem_q - 1'b1;
        burst_q <= burst_nxt;
        state   <= adv_state;
        bus_req <= (adv_state == RD);
        if (adv_state == DONE) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end

      // A failed read-back abandons the rest of the block but still reports completion.
      if (vfy_fail) begin
        err     <= 1'b1;
        bus_req <= 1'b0;
        busy    <= 1'b0;
        done    <= 1'b1;
        state   <= DONE;
      end
    end
  end

endmodule
